// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: data width, PC defaults, FSM state
// and the fetch/decode pipeline payload.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC select: redirect target, sequential step, or hold.
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over a step; the add wraps naturally at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC to a zero-wait instruction memory and holds the
// returned word in a valid/ready register for decode, with redirect and halt.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            halted
);

    fetch_state_t    state_q;
    logic            halted_q;
    logic            if_valid_q;
    if_id_t          if_q;
    logic [XLEN-1:0] pc_q;
    logic            slot_free;
    logic            fetch;

    always_comb begin
        slot_free = !if_valid_q || if_ready;
        fetch     = (state_q == RUN) && !halt_req && !redirect_valid && slot_free;
    end

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .advance_i     (fetch),
        .pc_o          (pc_q)
    );

    // halt_req alone picks the next state, so a redirect coinciding with a
    // halt request still lands in HALT with the target held in the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            halted_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_q       <= '0;
        end else begin
            state_q  <= halt_req ? HALT : RUN;
            halted_q <= halt_req;
            if (redirect_valid) begin
                if_valid_q <= 1'b0;
            end else if (fetch) begin
                if_valid_q <= 1'b1;
                if_q       <= '{pc: pc_q, instr: imem_data};
            end else if (if_ready) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_q.pc;
    assign if_instr  = if_q.instr;
    assign halted    = halted_q;

endmodule
